// File: rtl/dnn_pkg.sv
// Shared FP16 types and constants for the inference-engine front end.
package dnn_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t       FP16_ONE      = 16'h3C00;
  localparam fp16_t       FP16_ZERO     = 16'h0000;
  localparam int unsigned FP16_EXP_BIAS = 15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_BUSY
  } stager_state_t;

endpackage

// File: rtl/input_stager_if.sv
// Sample stream plus engine-side vector handshake for input_stager.
interface input_stager_if
  import dnn_pkg::*;
#(
  parameter int unsigned NUMBER_INPUTS96 = 6
);

  logic                             s_valid96;
  logic [7:0]                       s_data96;
  logic                             s_last96;
  logic                             s_ready96;
  logic [1:0]                       loaded_in96;
  logic                             in_ready96;
  fp16_t [NUMBER_INPUTS96-1:0]      in_neuron_values96;
  logic                             frame_err96;

  modport slave (
    input  s_valid96, s_data96, s_last96, loaded_in96,
    output s_ready96, in_ready96, in_neuron_values96, frame_err96
  );

  modport master (
    output s_valid96, s_data96, s_last96, loaded_in96,
    input  s_ready96, in_ready96, in_neuron_values96, frame_err96
  );

endinterface

// File: rtl/u8_to_fp16.sv
// Exact combinational conversion of an 8-bit unsigned integer to IEEE-754 binary16.
module u8_to_fp16
  import dnn_pkg::*;
(
  input  logic [7:0] x,
  output fp16_t      y
);

  logic [2:0] msb;
  logic [9:0] mant;

  always_comb begin
    msb = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (x[i]) msb = 3'(i);
    end
    // Shift the leading one up to bit 10 so it drops out as the hidden bit.
    mant = 10'(18'(x) << (4'd10 - 4'(msb)));
    if (x == '0) y = FP16_ZERO;
    else         y = {1'b0, 5'(FP16_EXP_BIAS + 32'(msb)), mant};
  end

endmodule

// File: rtl/input_stager.sv
// Assembles serial 8-bit samples into ping-pong FP16 vectors and offers them to the engine.
module input_stager
  import dnn_pkg::*;
#(
  parameter int unsigned NUMBER_INPUTS96 = 6
)
(
  input logic            clk96,
  input logic            rst96,
  input_stager_if.slave  bus
);

  localparam int unsigned    CW   = $clog2(NUMBER_INPUTS96);
  localparam logic [CW-1:0]  LAST = CW'(NUMBER_INPUTS96 - 1);

  fp16_t [1:0][NUMBER_INPUTS96-1:0] bank;
  fp16_t [NUMBER_INPUTS96-1:0]      values_q;
  logic  [1:0]                      full;
  logic  [1:0]                      full_set;
  logic  [1:0]                      full_clr;
  logic                             wr_bank;
  logic                             rd_bank;
  logic  [CW-1:0]                   cnt;
  logic                             in_ready_q;
  logic                             frame_err_q;
  fp16_t                            sample_fp;
  logic                             accept;
  logic                             last_slot;
  logic                             present_go;
  logic                             capture_go;
  stager_state_t                    state;
  stager_state_t                    state_next;

  u8_to_fp16 u_conv (
    .x (bus.s_data96),
    .y (sample_fp)
  );

  assign bus.s_ready96          = !rst96 && !full[wr_bank];
  assign accept                 = bus.s_valid96 && bus.s_ready96;
  assign last_slot              = (cnt == LAST);
  assign bus.in_ready96         = in_ready_q;
  assign bus.in_neuron_values96 = values_q;
  assign bus.frame_err96        = frame_err_q;

  always_ff @(posedge clk96) begin
    if (accept) bank[wr_bank][cnt] <= sample_fp;
  end

  // A bank completing and a bank being released on one edge touch different banks.
  always_comb begin
    full_set = '0;
    full_clr = '0;
    if (accept && last_slot) full_set[wr_bank] = 1'b1;
    if (capture_go)          full_clr[rd_bank] = 1'b1;
  end

  always_ff @(posedge clk96 or posedge rst96) begin
    if (rst96) begin
      cnt         <= '0;
      wr_bank     <= 1'b0;
      frame_err_q <= 1'b0;
      full        <= '0;
    end else begin
      frame_err_q <= 1'b0;
      full        <= (full | full_set) & ~full_clr;
      if (accept) begin
        if (last_slot) begin
          cnt         <= '0;
          wr_bank     <= ~wr_bank;
          frame_err_q <= !bus.s_last96;
        end else if (bus.s_last96) begin
          cnt         <= '0;
          frame_err_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk96 or posedge rst96) begin
    if (rst96) state <= ST_IDLE;
    else       state <= state_next;
  end

  // BUSY waits for both engine layers so the hidden pass (2'b10) never re-captures.
  always_comb begin
    state_next = state;
    present_go = 1'b0;
    capture_go = 1'b0;
    case (state)
      ST_IDLE: begin
        if (full[rd_bank] && bus.loaded_in96 == 2'b00) begin
          present_go = 1'b1;
          state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (bus.loaded_in96[0]) begin
          capture_go = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.loaded_in96 == 2'b00) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk96 or posedge rst96) begin
    if (rst96) begin
      in_ready_q <= 1'b0;
      values_q   <= '0;
      rd_bank    <= 1'b0;
    end else begin
      if (present_go) begin
        in_ready_q <= 1'b1;
        values_q   <= bank[rd_bank];
      end else if (capture_go) begin
        in_ready_q <= 1'b0;
        rd_bank    <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_input_stager.sv
// Bench for input_stager: sample source, two-layer engine model and vector scoreboard.
module tb_input_stager;
  import dnn_pkg::*;

  localparam int unsigned N = 6;
  typedef logic [N*16-1:0] vec_t;
  typedef struct {
    logic [7:0] x;
    fp16_t      y;
  } conv_vec_t;

  localparam vec_t V_A = {16'h5BF8, 16'h5800, 16'h4600, 16'h4500, 16'h4000, 16'h3C00};

  logic clk96 = 1'b0;
  logic rst96 = 1'b1;

  input_stager_if #(.NUMBER_INPUTS96(N)) bus ();

  input_stager #(.NUMBER_INPUTS96(N)) dut (
    .clk96 (clk96),
    .rst96 (rst96),
    .bus   (bus)
  );

  always #5 clk96 = ~clk96;

  int unsigned tests      = 0;
  int unsigned fails      = 0;
  int unsigned n_accepted = 0;
  int unsigned fe_count   = 0;
  logic        engine_auto = 1'b0;
  vec_t        sb[$];
  conv_vec_t   tbl[18];

  task automatic check(input string name, input vec_t act, input vec_t req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic send(input logic [7:0] d, input logic l);
    int unsigned w = 0;
    bus.s_valid96 = 1'b1;
    bus.s_data96  = d;
    bus.s_last96  = l;
    while (!bus.s_ready96 && w < 200) begin
      @(negedge clk96);
      w++;
    end
    if (!bus.s_ready96) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: s_ready96 got 0, required 1 within 200 cycles");
      bus.s_valid96 = 1'b0;
    end else begin
      @(negedge clk96);
      bus.s_valid96 = 1'b0;
      bus.s_last96  = 1'b0;
      n_accepted++;
    end
  endtask

  task automatic send_vec(input vec_t v, input logic last_flag);
    for (int unsigned i = 0; i < N; i++) begin
      logic [7:0] x;
      x = 8'd0;
      case (v[16*i +: 16])
        16'h3C00: x = 8'd1;
        16'h4000: x = 8'd2;
        16'h4500: x = 8'd5;
        16'h4600: x = 8'd6;
        16'h5800: x = 8'd128;
        16'h5BF8: x = 8'd255;
        default:  x = 8'd0;
      endcase
      send(x, (i == N - 1) ? last_flag : 1'b0);
    end
  endtask

  task automatic wait_drain();
    int unsigned w = 0;
    while ((sb.size() != 0 || bus.loaded_in96 != 2'b00 || bus.in_ready96) && w < 500) begin
      @(negedge clk96);
      w++;
    end
    tests++;
    if (w >= 500) begin
      fails++;
      $display("FAIL drain_timeout: %0d vectors still pending, required 0", sb.size());
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk96);
    #2 rst96 = 1'b1;
    #1;
    check("rst_in_ready", vec_t'(bus.in_ready96), '0);
    check("rst_values", vec_t'(bus.in_neuron_values96), '0);
    check("rst_s_ready", vec_t'(bus.s_ready96), '0);
    check("rst_frame_err", vec_t'(bus.frame_err96), '0);
    @(negedge clk96);
    rst96 = 1'b0;
    #1;
    check("post_rst_s_ready", vec_t'(bus.s_ready96), 1);
  endtask

  // Engine: captures one edge after seeing in_ready96, then runs layer 1 and layer 2.
  initial begin
    forever begin
      @(negedge clk96);
      if (engine_auto && !rst96 && bus.loaded_in96 == 2'b00 && bus.in_ready96) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_vector: got %h, required none", bus.in_neuron_values96);
        end else begin
          check("vector", vec_t'(bus.in_neuron_values96), sb.pop_front());
        end
        @(negedge clk96);
        check("in_ready_cycle2", vec_t'(bus.in_ready96), 1);
        bus.loaded_in96 = 2'b01;
        @(negedge clk96);
        check("in_ready_drop", vec_t'(bus.in_ready96), 0);
        repeat (7) @(negedge clk96);
        bus.loaded_in96 = 2'b10;
        repeat (8) @(negedge clk96);
        bus.loaded_in96 = 2'b00;
      end
    end
  end

  always @(negedge clk96) begin
    if (bus.frame_err96) fe_count++;
    if (bus.loaded_in96 == 2'b10) check("no_offer_during_hidden", vec_t'(bus.in_ready96), 0);
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        acc;
    int unsigned fe0;
    int unsigned hi;
    int unsigned w;

    tbl = '{
      '{8'd0,   16'h0000}, '{8'd3,   16'h4200}, '{8'd7,   16'h4700},
      '{8'd15,  16'h4B80}, '{8'd16,  16'h4C00}, '{8'd42,  16'h5140},
      '{8'd64,  16'h5400}, '{8'd100, 16'h5640}, '{8'd200, 16'h5A40},
      '{8'd1,   16'h3C00}, '{8'd2,   16'h4000}, '{8'd128, 16'h5800},
      '{8'd255, 16'h5BF8}, '{8'd5,   16'h4500}, '{8'd6,   16'h4600},
      '{8'd0,   16'h0000}, '{8'd254, 16'h5BF0}, '{8'd9,   16'h4880}
    };
    acc = '0;
    bus.s_valid96   = 1'b0;
    bus.s_data96    = 8'd0;
    bus.s_last96    = 1'b0;
    bus.loaded_in96 = 2'b00;

    #12;
    check("reset_in_ready", vec_t'(bus.in_ready96), '0);
    check("reset_values", vec_t'(bus.in_neuron_values96), '0);
    check("reset_frame_err", vec_t'(bus.frame_err96), '0);
    check("reset_s_ready", vec_t'(bus.s_ready96), '0);
    @(negedge clk96);
    rst96 = 1'b0;
    #1;
    check("release_s_ready", vec_t'(bus.s_ready96), 1);
    engine_auto = 1'b1;

    // Single vector and presentation latency
    @(negedge clk96);
    send_vec(V_A, 1'b1);
    sb.push_back(V_A);
    check("in_ready_not_yet", vec_t'(bus.in_ready96), 0);
    @(negedge clk96);
    check("in_ready_rise", vec_t'(bus.in_ready96), 1);
    wait_drain();

    // Conversion table streamed as three back-to-back vectors
    for (int unsigned i = 0; i < 18; i++) begin
      send(tbl[i].x, (i % N) == N - 1);
      acc[16*(i % N) +: 16] = tbl[i].y;
      if ((i % N) == N - 1) sb.push_back(acc);
    end
    wait_drain();

    // Framing: early last, then good vector, then missing last
    fe0 = fe_count;
    send(8'd7, 1'b0);
    send(8'd7, 1'b0);
    send(8'd7, 1'b1);
    @(negedge clk96); #1;
    check("frame_err_early_last", vec_t'(fe_count - fe0), 1);
    send_vec(V_A, 1'b1);
    sb.push_back(V_A);
    @(negedge clk96); #1;
    check("frame_err_clean", vec_t'(fe_count - fe0), 1);
    send_vec(V_A, 1'b0);
    sb.push_back(V_A);
    @(negedge clk96); #1;
    check("frame_err_missing_last", vec_t'(fe_count - fe0), 2);
    wait_drain();

    // Back-pressure with the engine held busy
    engine_auto     = 1'b0;
    bus.loaded_in96 = 2'b10;
    n_accepted      = 0;
    fork
      begin
        for (int unsigned i = 0; i < 18; i++) begin
          send(tbl[i].x, (i % N) == N - 1);
          acc[16*(i % N) +: 16] = tbl[i].y;
          if ((i % N) == N - 1) sb.push_back(acc);
        end
      end
      begin
        w = 0;
        while (n_accepted < 12 && w < 300) begin
          @(negedge clk96); #1;
          w++;
        end
        check("bp_s_ready_low", vec_t'(bus.s_ready96), 0);
        repeat (5) @(negedge clk96);
        #1;
        check("bp_stalled_count", vec_t'(n_accepted), 12);
        bus.loaded_in96 = 2'b00;
        engine_auto     = 1'b1;
        w = 0;
        while (bus.loaded_in96 != 2'b01 && w < 50) begin
          @(negedge clk96); #1;
          w++;
        end
        check("bp_s_ready_before_capture", vec_t'(bus.s_ready96), 0);
        @(negedge clk96); #1;
        check("bp_s_ready_after_capture", vec_t'(bus.s_ready96), 1);
      end
    join
    wait_drain();

    // Reset mid-fill
    engine_auto = 1'b0;
    send(8'd200, 1'b0);
    send(8'd100, 1'b0);
    send(8'd42, 1'b0);
    pulse_reset();
    engine_auto = 1'b1;
    sb.push_back(V_A);
    send_vec(V_A, 1'b1);
    wait_drain();

    // Reset while a vector is being offered
    engine_auto = 1'b0;
    send_vec(V_A, 1'b1);
    w = 0;
    while (!bus.in_ready96 && w < 50) begin
      @(negedge clk96); #1;
      w++;
    end
    check("offer_before_reset", vec_t'(bus.in_ready96), 1);
    pulse_reset();
    hi = 0;
    repeat (20) begin
      @(negedge clk96);
      if (bus.in_ready96) hi++;
    end
    check("no_stale_vector", vec_t'(hi), 0);
    engine_auto = 1'b1;
    sb.push_back(V_A);
    send_vec(V_A, 1'b1);
    wait_drain();

    check("frame_err_total", vec_t'(fe_count), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/input_stager.md
# input_stager

Upstream feeder for the two-layer FP16 inference engine. It accepts a serial stream of 8-bit unsigned input samples over a valid/ready handshake and converts each sample to IEEE-754 binary16. It assembles `NUMBER_INPUTS96` samples into a ping-pong buffered vector and presents that vector on the engine's parallel `in_ready96`/`in_neuron_values96` interface. It sequences presentation against the engine's `loaded_in96` status, so a new vector is never offered while a previous inference is still in flight.

## Interface
Parameters:
- `NUMBER_INPUTS96`, default 6: samples per vector. Must match the engine. Range 2..15.

Ports (one clock; reset is asynchronous and active-high):
- `clk96` in 1: clock.
- `rst96` in 1: asynchronous, active-high reset.
- `s_valid96` in 1: sample valid.
- `s_data96` in 8: unsigned sample.
- `s_last96` in 1: marks the final sample of a vector.
- `s_ready96` out 1: sample accepted on `s_valid96 && s_ready96`.
- `loaded_in96` in 2: engine status, driven by the engine's `loaded_in96` output.
- `in_ready96` out 1: vector offered to the engine.
- `in_neuron_values96` out `[NUMBER_INPUTS96-1:0][15:0]`: FP16 vector. Element 0 is the first sample received.
- `frame_err96` out 1: one-cycle pulse when `s_last96` placement is wrong.

## Operation
- Two banks, each holding `NUMBER_INPUTS96` FP16 words.
  - Each bank has a `full` flag.
  - `wr_bank` selects the bank being filled; `rd_bank` selects the next bank to present.
  - A sample counter `cnt` runs 0..N-1.
- `s_ready96 = !full[wr_bank]`. It is combinational and is 0 while `rst96` is high.
- Conversion of sample x to FP16 is exact:
  - x = 0 → 0x0000.
  - Otherwise, with p = index of the MSB of x: sign 0, exponent 15+p, mantissa = (x << (10-p))[9:0].
  - Examples: 1→0x3C00, 2→0x4000, 5→0x4500, 6→0x4600, 128→0x5800, 255→0x5BF8.
- Each accepted sample is converted and written to `bank[wr_bank][cnt]`.
- Framing rules:
  - `s_last96` with `cnt < N-1`: pulse `frame_err96`, discard the partial bank, reset `cnt` to 0. The same bank is refilled.
  - Sample at `cnt == N-1`: the bank completes. Set `full[wr_bank]`, toggle `wr_bank`, reset `cnt` to 0. If `s_last96` is 0 on this sample, also pulse `frame_err96`; the bank is still kept.
- Presentation FSM has three states: IDLE, PRESENT, BUSY.
  - IDLE → PRESENT when `full[rd_bank] && loaded_in96 == 2'b00`. On this edge, copy the bank into the `in_neuron_values96` register and set `in_ready96` to 1.
  - PRESENT → BUSY when `loaded_in96[0] == 1`, i.e. the engine has captured the vector. On this edge: `in_ready96` ← 0, clear `full[rd_bank]`, toggle `rd_bank`. `in_neuron_values96` holds its value.
  - BUSY → IDLE when `loaded_in96 == 2'b00`, i.e. both engine layers are done. This prevents re-capture during the hidden-layer pass (`loaded_in96 == 2'b10`).
- Simultaneous events:
  - A bank completing and a bank being freed on the same edge are both applied.
  - Writing one bank while the other is presented is legal.
  - When both banks are full, `s_ready96` = 0 until the PRESENT→BUSY edge.
- Reset, including mid-operation, applies these values:
  - `in_ready96` = 0, `in_neuron_values96` = 0, `frame_err96` = 0.
  - All `full` flags clear, `cnt` = 0, both bank pointers = 0, FSM = IDLE.
  - Partial and buffered vectors are lost.
  - Because IDLE waits for `loaded_in96 == 2'b00`, an engine still busy across our reset is never disturbed.

## Timing
- Converter is combinational; bank write is registered on the accept edge.
- A vector completes at edge k. If the engine is idle, `in_ready96` is high and `in_neuron_values96` is valid after edge k+1.
- The engine raises `loaded_in96[0]` one edge after sampling `in_ready96`. `in_ready96` drops on the following edge. `in_ready96` is therefore high for exactly 2 cycles per vector against the engine.
- `frame_err96` is asserted for the cycle after the offending accept edge.
- Throughput: a full stream at 1 sample/cycle stalls only when both banks await the engine.

## Structure
- Shared package `dnn_pkg`:
  - FP16 constants: `FP16_ONE` = 16'h3C00, `FP16_ZERO`, `FP16_EXP_BIAS` = 15.
  - `typedef logic [15:0] fp16_t`.
  - FSM state enum `stager_state_t`.
- One sub-module, `u8_to_fp16`: combinational 8-bit unsigned to FP16 converter (priority encoder plus shift). It is reused by other front-end stages.

## Test plan
- **Single vector.** Stream 1,2,5,6,128,255 with `s_last96` on the 6th sample; engine model idle. Required: `in_neuron_values96` = {0x5BF8,0x5800,0x4600,0x4500,0x4000,0x3C00} (element 5 down to element 0); `in_ready96` rises one cycle after the last accept; no `frame_err96`.
- **Engine handshake.** Model `loaded_in96` as 00→01 (one cycle after `in_ready96`), held 8 cycles, →10 for 8 cycles, →00. Required: `in_ready96` = 1 for exactly 2 cycles; the second buffered vector is presented only after `loaded_in96` returns to 00, never during 10.
- **Back-pressure.** Stream 3 vectors continuously while the engine stays busy. Required: `s_ready96` = 0 after the 12th accepted sample; it returns to 1 on the edge the first vector is captured; no data loss or reordering.
- **Framing errors.** Assert `s_last96` on the 3rd sample. Required: one `frame_err96` pulse, partial vector discarded, the next 6 samples form the vector. Omit `s_last96` on the 6th sample: one pulse, vector still presented.
- **Zero sample and reset.** Sample 0 → 0x0000. Assert `rst96` mid-fill and mid-PRESENT. Required: outputs go to 0 immediately (asynchronous); after release `s_ready96` = 1, FSM IDLE, and no stale vector is presented.
